// File: rtl/vend_pkg.sv
// Shared encodings and coin constants for the vending output path.
// Build option COIN10_EJECT_EN enables 10-coin change (see change_dispenser).
package vend_pkg;

  localparam int COIN5_UNITS  = 1;
  localparam int COIN10_UNITS = 2;
  localparam int DEF_PRICE    = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PROD  = 3'd1;
  localparam logic [2:0] S_SEL   = 3'd2;
  localparam logic [2:0] S_REQ10 = 3'd3;
  localparam logic [2:0] S_REQ5  = 3'd4;
  localparam logic [2:0] S_ACKLO = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_PROD  = S_PROD,
    ST_SEL   = S_SEL,
    ST_REQ10 = S_REQ10,
    ST_REQ5  = S_REQ5,
    ST_ACKLO = S_ACKLO,
    ST_FIN   = S_FIN
  } state_t;

endpackage

// File: rtl/change_dispenser_coin_handshake.sv
// One 4-phase req/ack channel to the coin ejector.
// COIN10_EJECT_EN undefined: coin10_req is tied low.
module coin_handshake (
  input  logic clk,
  input  logic Reset,
  input  logic start,
  input  logic sel10,
  input  logic ack,
  output logic coin5_req,
  output logic coin10_req,
  output logic ack_done
);

  logic req;
  logic is10;

  // req rises on start, falls on the first cycle ack is seen high
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      req  <= 1'b0;
      is10 <= 1'b0;
    end else if (start) begin
      req  <= 1'b1;
      is10 <= sel10;
    end else if (req && ack) begin
      req  <= 1'b0;
    end
  end

  assign ack_done  = req & ack;
  assign coin5_req = req & ~is10;
`ifdef COIN10_EJECT_EN
  assign coin10_req = req & is10;
`else
  assign coin10_req = 1'b0;
`endif

endmodule

// File: rtl/change_dispenser.sv
// Vend/refund controller: product pulse, then change as coins.
// COIN10_EJECT_EN defined: greedy 10-coins first; else 5-coins only.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int PRICE    = DEF_PRICE,
  parameter int PROD_LEN = 4
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                vend_req,
  input  logic                refund_req,
  input  logic                coin_ack,
  output logic                coin5_req,
  output logic                coin10_req,
  output logic                product,
  output logic                busy,
  output logic                denied,
  output logic                done,
  output logic [CREDIT_W-1:0] change_left
);

  localparam int PW = (PROD_LEN > 1) ? $clog2(PROD_LEN) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PROD_LEN - 1);
  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] C5  = CREDIT_W'(COIN5_UNITS);
  localparam logic [CREDIT_W-1:0] C10 = CREDIT_W'(COIN10_UNITS);

  state_t              state;
  state_t              nxt;
  logic [CREDIT_W-1:0] chg;
  logic [CREDIT_W-1:0] chg_nxt;
  logic [PW-1:0]       pcnt;
  logic                hs_start;
  logic                hs_sel10;
  logic                hs_done;

  // state and remaining-change registers
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      chg   <= '0;
    end else begin
      state <= nxt;
      chg   <= chg_nxt;
    end
  end

  // product pulse length counter, cleared outside PROD
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pcnt <= '0;
    end else if (state == ST_PROD) begin
      pcnt <= pcnt + 1'b1;
    end else begin
      pcnt <= '0;
    end
  end

  // next state, change arithmetic and coin launch
  always_comb begin
    nxt      = state;
    chg_nxt  = chg;
    hs_start = 1'b0;
    hs_sel10 = 1'b0;
    denied   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (refund_req) begin
          chg_nxt = credit;
          nxt     = ST_SEL;
        end else if (vend_req) begin
          if (credit >= PRICE_V) begin
            chg_nxt = credit - PRICE_V;
            nxt     = ST_PROD;
          end else begin
            denied = 1'b1;
          end
        end
      end
      ST_PROD: begin
        if (pcnt == PLAST) nxt = ST_SEL;
      end
      ST_SEL: begin
        if (chg == '0) begin
          nxt = ST_FIN;
`ifdef COIN10_EJECT_EN
        end else if (chg >= C10) begin
          nxt      = ST_REQ10;
          hs_start = 1'b1;
          hs_sel10 = 1'b1;
`endif
        end else begin
          nxt      = ST_REQ5;
          hs_start = 1'b1;
        end
      end
`ifdef COIN10_EJECT_EN
      ST_REQ10: begin
        if (hs_done) begin
          chg_nxt = chg - C10;
          nxt     = ST_ACKLO;
        end
      end
`endif
      ST_REQ5: begin
        if (hs_done) begin
          chg_nxt = chg - C5;
          nxt     = ST_ACKLO;
        end
      end
      ST_ACKLO: begin
        if (!coin_ack) nxt = ST_SEL;
      end
      ST_FIN: begin
        nxt = ST_IDLE;
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
  end

  coin_handshake u_hs (
    .clk        (clk),
    .Reset      (Reset),
    .start      (hs_start),
    .sel10      (hs_sel10),
    .ack        (coin_ack),
    .coin5_req  (coin5_req),
    .coin10_req (coin10_req),
    .ack_done   (hs_done)
  );

  assign busy        = (state != ST_IDLE);
  assign product     = (state == ST_PROD);
  assign done        = (state == ST_FIN);
  assign change_left = chg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a coin scoreboard.
// Expectations follow COIN10_EJECT_EN when defined.
module tb_change_dispenser;

`ifdef COIN10_EJECT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int PRICE = 3;
  localparam int PLEN  = 4;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] credit = '0;
  logic       vend_req = 1'b0;
  logic       refund_req = 1'b0;
  logic       coin_ack = 1'b0;
  logic       coin5_req, coin10_req, product;
  logic       busy, denied, done;
  logic [3:0] change_left;

  typedef struct {
    bit is10;
    int left;
  } coin_t;

  coin_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  change_dispenser #(.CREDIT_W(4), .PRICE(PRICE), .PROD_LEN(PLEN)) dut (
    .clk(clk), .Reset(Reset), .credit(credit),
    .vend_req(vend_req), .refund_req(refund_req),
    .coin_ack(coin_ack), .coin5_req(coin5_req),
    .coin10_req(coin10_req), .product(product),
    .busy(busy), .denied(denied), .done(done),
    .change_left(change_left)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_change(input int ch);
    int c = ch;
    while (c > 0) begin
      coin_t e;
      if (EN && c >= 2) begin
        e.is10 = 1'b1;
        c -= 2;
      end else begin
        e.is10 = 1'b0;
        c -= 1;
      end
      e.left = c;
      q.push_back(e);
    end
  endtask

  task automatic serve(input int maxdly);
    while (q.size() > 0) begin
      coin_t e;
      int w = 0;
      while (!(coin5_req || coin10_req) && w < 60) begin
        @(negedge clk);
        w++;
      end
      if (w >= 60) begin
        chk("coin_timeout", 0, 1);
        q.delete();
        break;
      end
      e = q.pop_front();
      chk("coin10_req", coin10_req, e.is10);
      chk("coin5_req", coin5_req, !e.is10);
      repeat ($urandom_range(maxdly)) @(negedge clk);
      chk("req_held", coin5_req | coin10_req, 1);
      coin_ack = 1'b1;
      @(negedge clk);
      chk("req_drop", coin5_req | coin10_req, 0);
      chk("change_left", change_left, e.left);
      repeat ($urandom_range(maxdly)) @(negedge clk);
      chk("no_double_dec", change_left, e.left);
      chk("no_rereq", coin5_req | coin10_req, 0);
      coin_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done && w < 12) begin
      @(negedge clk);
      w++;
    end
    chk("done", done, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic txn(input int cr, input bit v, input bit r,
                     input int maxdly);
    @(negedge clk);
    credit     = 4'(cr);
    vend_req   = v;
    refund_req = r;
    if (!r && cr < PRICE) begin
      #1;
      chk("denied", denied, 1);
      @(negedge clk);
      vend_req = 1'b0;
      #1;
      chk("denied_pulse", denied, 0);
      chk("denied_busy", busy, 0);
      chk("denied_prod", product, 0);
      chk("denied_chg", change_left, 0);
      chk("denied_coin", coin5_req | coin10_req, 0);
      return;
    end
    push_change(r ? cr : cr - PRICE);
    @(negedge clk);
    vend_req   = 1'b0;
    refund_req = 1'b0;
    chk("busy", busy, 1);
    if (!r) begin
      for (int i = 0; i < PLEN; i++) begin
        chk("product_on", product, 1);
        @(negedge clk);
      end
    end
    chk("product_off", product, 0);
    serve(maxdly);
    wait_done();
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_chg", change_left, 0);
    chk("rst_coin", {coin5_req, coin10_req, product, done}, 0);
    repeat (2) @(negedge clk);
    Reset = 1'b1;

    txn(4, 1'b1, 1'b0, 2);
    txn(5, 1'b0, 1'b1, 3);
    txn(2, 1'b1, 1'b0, 0);
    txn(3, 1'b1, 1'b0, 1);
    txn(0, 1'b0, 1'b1, 0);

    // simultaneous requests: refund wins; extra request while busy
    @(negedge clk);
    credit     = 4'd3;
    vend_req   = 1'b1;
    refund_req = 1'b1;
    push_change(3);
    @(negedge clk);
    refund_req = 1'b0;
    chk("sim_no_prod", product, 0);
    credit = 4'd15;
    @(negedge clk);
    vend_req = 1'b0;
    chk("sim_no_prod2", product, 0);
    serve(2);
    wait_done();
    chk("sim_idle_prod", product, 0);

    txn(15, 1'b0, 1'b1, 20);
    txn(13, 1'b1, 1'b0, 20);

    // async reset with a coin in flight
    @(negedge clk);
    credit     = 4'd5;
    refund_req = 1'b1;
    @(negedge clk);
    refund_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", coin10_req, EN);
    chk("pre_rst_req5", coin5_req, !EN);
    #2 Reset = 1'b0;
    #1;
    chk("arst_coin", {coin5_req, coin10_req}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_chg", change_left, 0);
    chk("arst_misc", {product, done, denied}, 0);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    txn(2, 1'b0, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
